data_memory_responder: RTL and testbench
========================================

# data_memory_responder

Responder end of the core's data-memory interface: it accepts load/store requests from the RV64I dataflow, waits a fixed number of wait states, and then performs the access on a 64-bit-wide, byte-lane-addressed internal RAM. It completes each access with a one-cycle acknowledge. Load data is returned right-aligned and zero-filled, so the core's own read-data extender still performs sign or zero extension. It sits between the core's data port and the on-chip data RAM.

## Interface
- `addr_size`, 10: doubleword-index width; capacity 2^addr_size × 8 bytes (default 8 KiB).
- `busy_cycles`, 2: wait states between acceptance and acknowledge (0..15).
- `clock` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `rd_enable` input 1: load request.
- `wr_enable` input 1: store request.
- `data_address` input 64: byte address. Bits [addr_size+2:3] select the doubleword, bits [2:0] select the byte; higher bits are ignored (aliasing).
- `size` input 2: 00 byte, 01 half, 10 word, 11 double.
- `write_data` input 64: store data, right-aligned (taken from rs2).
- `read_data` output 64: load result, right-aligned, upper bytes zero.
- `busy` output 1: request in flight.
- `ack` output 1: one-cycle completion pulse.
- `error` output 1: valid with `ack`; misaligned access or `rd_enable` and `wr_enable` both set.

## Operation
- FSM states: IDLE, WAIT, RESPOND.
- **IDLE**
  - If `rd_enable | wr_enable`, latch `data_address`, `size`, `write_data`, op and error status.
  - Go to WAIT with counter = `busy_cycles`, or straight to RESPOND if `busy_cycles` = 0.
- **WAIT**
  - Decrement the counter each cycle.
  - At 1, go to RESPOND.
- **RESPOND**
  - Assert `ack`.
  - Commit the write or capture the read.
  - Return to IDLE.
- Requests are sampled only in IDLE. Enables in WAIT or RESPOND are ignored, not queued.
- Misaligned when `data_address[2:0]` is not a multiple of 2^`size`:
  - `error`=1 at the normal ack time;
  - no RAM write;
  - `read_data` unchanged.
- Both enables set: `error`=1, no access, same timing.
- **Store**
  - Byte-enable mask = (2^(2^size)−1) << addr[2:0].
  - Lane data = `write_data` << 8·addr[2:0].
  - Only enabled bytes change.
- **Load**
  - `read_data` = (doubleword >> 8·addr[2:0]) masked to 2^size bytes.
  - `read_data` updates only on a successful load ack and holds until the next one.
- RAM contents are not affected by `reset`.

## Timing
- Request accepted at edge T (state IDLE) → `busy`=1 from T+1 through the ack cycle.
- `ack`=1 for exactly one cycle, at T+1+`busy_cycles`.
- `read_data` is valid in the ack cycle.
- The earliest next acceptance is the cycle after ack, giving a throughput of one access per `busy_cycles`+2 cycles.
- Latched request: inputs may change after T without effect.
- Store commit: RAM is written at the ack edge; a load accepted afterwards sees the new data.
- Reset values: `read_data`=0, `busy`=0, `ack`=0, `error`=0; state IDLE; counter 0.
- Reset during WAIT aborts the request, and the pending store is never written.
- Reset coincident with RESPOND: reset wins, no commit, no ack.

## Structure
- Shared package/header holds:
  - size codes (`SIZE_B`, `SIZE_H`, `SIZE_W`, `SIZE_D`);
  - FSM state encoding (2 bits);
  - misalignment predicate.
- Sub-module `byte_enable_ram`: single-port synchronous 64-bit RAM, depth 2^`addr_size`, 8 byte-write enables, registered read.
- Request latch reuses `register_d`.

## Test plan
1. Reset, then a store of double `0x1122334455667788` at 0x40 (busy_cycles=2) → `busy` high 3 cycles, `ack` at T+3 with `error`=0. A load of double at 0x40 → `read_data`=0x1122334455667788.
2. Store byte 0xAB at 0x43, then load double at 0x40 → 0x11223344AB667788. Load byte at 0x43 → 0x00000000000000AB.
3. Load half at 0x41 → `ack` at T+3, `error`=1, `read_data` unchanged. Store word at 0x46 → `error`=1, RAM unchanged.
4. `rd_enable` and `wr_enable` both set → `error`=1 at ack, no write. Enables pulsed during WAIT → ignored; exactly one ack.
5. Store accepted, then `reset` asserted in WAIT → no ack, outputs 0. A subsequent load shows the old RAM data.
6. With `busy_cycles`=0: `ack` at T+1. Back-to-back requests held high → ack every 2 cycles. Address 0x40 + 2^(addr_size+3) aliases to 0x40.

Source files
------------

// File: rtl/data_memory_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : data_memory_responder_pkg
// Brief    : Shared size codes, FSM encoding and access helpers for the
//            data-memory responder.
// Revision : 1.0 - initial release
// ============================================================================
package data_memory_responder_pkg;

  // Access size codes as presented on the core's data port
  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [1:0] SIZE_D = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RESPOND = 2'd2
  } state_t;

  // An access is misaligned when the byte offset is not a multiple of its size.
  // For doublewords (1 << 3) wraps to zero in 3 bits, giving an all-ones mask.
  function automatic logic is_misaligned(input logic [2:0] off, input logic [1:0] sz);
    logic [2:0] m;
    m = (3'b001 << sz) - 3'b001;
    return (off & m) != 3'b000;
  endfunction

  // Byte-lane enables: 2^size contiguous bytes starting at the byte offset
  function automatic logic [7:0] byte_mask(input logic [2:0] off, input logic [1:0] sz);
    logic [15:0] m;
    m = (16'd1 << (5'd1 << sz)) - 16'd1;
    m = m << off;
    return m[7:0];
  endfunction

  // Keeps the low 2^size bytes of a right-aligned load result
  function automatic logic [63:0] size_mask(input logic [1:0] sz);
    logic [63:0] m;
    case (sz)
      SIZE_B:  m = 64'h0000_0000_0000_00FF;
      SIZE_H:  m = 64'h0000_0000_0000_FFFF;
      SIZE_W:  m = 64'h0000_0000_FFFF_FFFF;
      default: m = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/data_memory_responder_ram.sv
`default_nettype none
// ============================================================================
// Module   : byte_enable_ram
// Brief    : Single-port 64-bit synchronous RAM with eight byte-write
//            enables and a registered read port (read-before-write).
// Revision : 1.0 - initial release
// ============================================================================
module byte_enable_ram #(
  parameter int ADDR_W = 10
) (
  input  logic              clock,
  input  logic [7:0]        we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [63:0]       wdata,
  output logic [63:0]       rdata
);

  logic [63:0] mem_q [0:(1 << ADDR_W)-1];
  logic [63:0] rdata_q;

  // Per-lane write and registered read of the addressed doubleword
  always_ff @(posedge clock) begin
    for (int i = 0; i < 8; i++) begin
      if (we[i]) begin
        mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/register_d.sv
`default_nettype none
// ============================================================================
// Module   : register_d
// Brief    : Loadable D register with synchronous active-high clear.
// Revision : 1.0 - initial release
// ============================================================================
module register_d #(
  parameter int WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] value_q;

  // Capture d when load is asserted, clear on reset
  always_ff @(posedge clock) begin
    if (reset) begin
      value_q <= '0;
    end else if (load) begin
      value_q <= d;
    end
  end

  assign q = value_q;

endmodule
`default_nettype wire

// File: rtl/data_memory_responder.sv
`default_nettype none
// ============================================================================
// Module   : data_memory_responder
// Brief    : Data-memory responder: accepts a load/store, waits a fixed
//            number of wait states, accesses the byte-lane RAM and returns a
//            one-cycle ack with right-aligned, zero-filled load data.
// Revision : 1.0 - initial release
// ============================================================================
module data_memory_responder
  import data_memory_responder_pkg::*;
#(
  parameter int ADDR_SIZE   = 10,
  parameter int BUSY_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rd_enable,
  input  logic        wr_enable,
  input  logic [63:0] data_address,
  input  logic [1:0]  size,
  input  logic [63:0] write_data,
  output logic [63:0] read_data,
  output logic        busy,
  output logic        ack,
  output logic        error
);

  localparam int         AW          = ADDR_SIZE + 3;
  localparam int         LATCH_W     = AW + 2 + 64 + 1 + 1;
  localparam logic [3:0] c_busy_init = 4'(BUSY_CYCLES);

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        busy_q;
  logic        ack_q;
  logic        error_q;
  logic [63:0] read_data_q;

  // Request latch contents
  logic [LATCH_W-1:0] w_req_d;
  logic [LATCH_W-1:0] w_req_q;
  logic [AW-1:0]      req_addr_q;
  logic [1:0]         req_size_q;
  logic [63:0]        req_wdata_q;
  logic               req_store_q;
  logic               req_err_q;

  logic               w_accept;
  logic               w_req_err;
  logic               w_store_ok;
  logic               w_load_ok;
  logic [5:0]         w_lane_shift;
  logic [7:0]         w_we;
  logic [ADDR_SIZE-1:0] w_ram_addr;
  logic [63:0]        w_ram_rdata;
  logic [63:0]        w_load_data;
  logic               w_unused_addr_hi;

  // Address bits above the RAM range alias and are deliberately ignored
  assign w_unused_addr_hi = ^data_address[63:AW];

  assign w_accept  = (state_q == ST_IDLE) && (rd_enable || wr_enable);
  assign w_req_err = is_misaligned(data_address[2:0], size) || (rd_enable && wr_enable);
  assign w_req_d   = {data_address[AW-1:0], size, write_data, wr_enable, w_req_err};

  register_d #(
    .WIDTH (LATCH_W)
  ) u_req_latch (
    .clock (clock),
    .reset (reset),
    .load  (w_accept),
    .d     (w_req_d),
    .q     (w_req_q)
  );

  assign {req_addr_q, req_size_q, req_wdata_q, req_store_q, req_err_q} = w_req_q;

  assign w_store_ok   = !req_err_q &&  req_store_q;
  assign w_load_ok    = !req_err_q && !req_store_q;
  assign w_lane_shift = {req_addr_q[2:0], 3'b000};

  // In IDLE the RAM is pointed at the incoming address so that a zero-wait
  // request already has its doubleword available in the RESPOND cycle.
  assign w_ram_addr = (state_q == ST_IDLE) ? data_address[AW-1:3] : req_addr_q[AW-1:3];

  // The store commits on the edge that leaves RESPOND; reset on that edge wins.
  assign w_we = (state_q == ST_RESPOND && w_store_ok && !reset)
              ? byte_mask(req_addr_q[2:0], req_size_q) : 8'h00;

  byte_enable_ram #(
    .ADDR_W (ADDR_SIZE)
  ) u_ram (
    .clock (clock),
    .we    (w_we),
    .addr  (w_ram_addr),
    .wdata (req_wdata_q << w_lane_shift),
    .rdata (w_ram_rdata)
  );

  assign w_load_data = (w_ram_rdata >> w_lane_shift) & size_mask(req_size_q);

  // Request sequencing: accept in IDLE, count wait states, one-cycle respond
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      busy_q      <= 1'b0;
      ack_q       <= 1'b0;
      error_q     <= 1'b0;
      read_data_q <= 64'd0;
    end else begin
      ack_q   <= 1'b0;
      error_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (w_accept) begin
            busy_q <= 1'b1;
            if (BUSY_CYCLES == 0) begin
              state_q <= ST_RESPOND;
              ack_q   <= 1'b1;
              error_q <= w_req_err;
            end else begin
              state_q <= ST_WAIT;
              cnt_q   <= c_busy_init;
            end
          end
        end
        ST_WAIT: begin
          if (cnt_q == 4'd1) begin
            state_q <= ST_RESPOND;
            cnt_q   <= 4'd0;
            ack_q   <= 1'b1;
            error_q <= req_err_q;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_RESPOND: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          if (w_load_ok) begin
            read_data_q <= w_load_data;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Load data is presented live in the ack cycle and held afterwards
  assign read_data = (state_q == ST_RESPOND && w_load_ok) ? w_load_data : read_data_q;
  assign busy      = busy_q;
  assign ack       = ack_q;
  assign error     = error_q;

endmodule
`default_nettype wire

// File: tb/tb_data_memory_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_data_memory_responder
// Brief    : Scoreboard bench for the data-memory responder with two
//            instances: two wait states and zero wait states.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_memory_responder;
  import data_memory_responder_pkg::*;

  localparam int ADDR_SIZE = 10;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] data_address = '0;
  logic [63:0] write_data = '0;
  logic [1:0]  size = '0;
  logic        rd2 = 1'b0, wr2 = 1'b0, rd0 = 1'b0, wr0 = 1'b0;
  logic [63:0] rdata2, rdata0;
  logic        busy2, busy0, ack2, ack0, err2, err0;

  always #5 clock = ~clock;

  data_memory_responder #(.ADDR_SIZE(ADDR_SIZE), .BUSY_CYCLES(2)) dut2 (
    .clock(clock), .reset(reset), .rd_enable(rd2), .wr_enable(wr2),
    .data_address(data_address), .size(size), .write_data(write_data),
    .read_data(rdata2), .busy(busy2), .ack(ack2), .error(err2));

  data_memory_responder #(.ADDR_SIZE(ADDR_SIZE), .BUSY_CYCLES(0)) dut0 (
    .clock(clock), .reset(reset), .rd_enable(rd0), .wr_enable(wr0),
    .data_address(data_address), .size(size), .write_data(write_data),
    .read_data(rdata0), .busy(busy0), .ack(ack0), .error(err0));

  typedef struct {
    string       tag;
    logic        err;
    logic [63:0] rd;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] mem_model [int];
  logic [63:0] last_rd [2];
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%016h expected=0x%016h", tag, got, exp);
    end
  endtask

  function automatic logic get_ack(input int bc);
    return (bc == 2) ? ack2 : ack0;
  endfunction
  function automatic logic get_busy(input int bc);
    return (bc == 2) ? busy2 : busy0;
  endfunction
  function automatic logic get_err(input int bc);
    return (bc == 2) ? err2 : err0;
  endfunction
  function automatic logic [63:0] get_rd(input int bc);
    return (bc == 2) ? rdata2 : rdata0;
  endfunction

  task automatic set_en(input int bc, input logic rd, input logic wr);
    if (bc == 2) begin rd2 = rd; wr2 = wr; end
    else         begin rd0 = rd; wr0 = wr; end
  endtask

  // Byte-by-byte reference of one access; updates the model RAM and the
  // expected held load value of the chosen instance.
  function automatic void model(input int bc, input logic rd, input logic wr,
                                input logic [63:0] addr, input logic [1:0] sz,
                                input logic [63:0] wd, output logic err,
                                output logic [63:0] rdv);
    int          off, nb, key, idx;
    logic [63:0] dw;
    off = int'(addr[2:0]);
    nb  = 1 << sz;
    idx = (bc == 2) ? 1 : 0;
    err = ((off % nb) != 0) || (rd && wr);
    key = bc * 65536 + int'(addr[ADDR_SIZE+2:3]);
    dw  = mem_model.exists(key) ? mem_model[key] : 64'd0;
    if (!err && wr) begin
      for (int b = 0; b < nb; b++) dw[8*(off+b) +: 8] = wd[8*b +: 8];
      mem_model[key] = dw;
    end
    if (!err && rd) begin
      rdv = '0;
      for (int b = 0; b < nb; b++) rdv[8*b +: 8] = dw[8*(off+b) +: 8];
      last_rd[idx] = rdv;
    end
    rdv = last_rd[idx];
  endfunction

  // One request: drive for one accept edge, scramble the inputs afterwards,
  // then wait (bounded) for the ack and compare against the scoreboard.
  task automatic do_req(input string tag, input int bc, input logic rd, input logic wr,
                        input logic [63:0] addr, input logic [1:0] sz,
                        input logic [63:0] wd, input bit pulse,
                        output logic [63:0] got_rd);
    exp_t        e;
    logic        eerr;
    logic [63:0] erd;
    int          n;
    bit          seen;
    model(bc, rd, wr, addr, sz, wd, eerr, erd);
    e.tag = tag; e.err = eerr; e.rd = erd; e.lat = bc + 1;
    sb.push_back(e);
    data_address = addr; size = sz; write_data = wd;
    set_en(bc, rd, wr);
    @(posedge clock);
    @(negedge clock);
    set_en(bc, 1'b0, 1'b0);
    // Aliases onto doubleword 0x40, so an unlatched request would corrupt it
    data_address = 64'hFFFF_FFFF_FFFF_E040;
    size = ~sz;
    write_data = ~wd;
    n = 1;
    seen = 0;
    got_rd = '0;
    while (n <= 40 && !seen) begin
      if (get_ack(bc)) begin
        seen = 1;
      end else begin
        check_eq({tag, "_busy_wait"}, 64'(get_busy(bc)), 64'd1);
        if (pulse && n == 1) set_en(bc, 1'b1, 1'b1);
        else                 set_en(bc, 1'b0, 1'b0);
        @(negedge clock);
        n++;
      end
    end
    set_en(bc, 1'b0, 1'b0);
    e = sb.pop_front();
    if (!seen) begin
      check_eq({e.tag, "_ack_timeout"}, 64'(get_ack(bc)), 64'd1);
    end else begin
      got_rd = get_rd(bc);
      check_eq({e.tag, "_latency"}, 64'(n), 64'(e.lat));
      check_eq({e.tag, "_error"}, 64'(get_err(bc)), 64'(e.err));
      check_eq({e.tag, "_rdata"}, got_rd, e.rd);
      check_eq({e.tag, "_busy_ack"}, 64'(get_busy(bc)), 64'd1);
      @(negedge clock);
      check_eq({e.tag, "_ack_pulse"}, 64'(get_ack(bc)), 64'd0);
      check_eq({e.tag, "_busy_end"}, 64'(get_busy(bc)), 64'd0);
      check_eq({e.tag, "_rdata_hold"}, get_rd(bc), e.rd);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] got;
    logic        eerr;
    logic [63:0] erd;
    last_rd[0] = '0;
    last_rd[1] = '0;

    reset = 1'b1;
    repeat (3) @(negedge clock);
    check_eq("rst_rdata", rdata2, 64'd0);
    check_eq("rst_busy",  64'(busy2), 64'd0);
    check_eq("rst_ack",   64'(ack2), 64'd0);
    check_eq("rst_error", 64'(err2), 64'd0);
    check_eq("rst_rdata0", rdata0, 64'd0);
    reset = 1'b0;
    @(negedge clock);

    // Basic doubleword store and load
    do_req("st_d_40", 2, 1'b0, 1'b1, 64'h40, SIZE_D, 64'h1122_3344_5566_7788, 1'b0, got);
    do_req("ld_d_40", 2, 1'b1, 1'b0, 64'h40, SIZE_D, 64'h0, 1'b0, got);
    check_eq("tp1_ld_d", got, 64'h1122_3344_5566_7788);

    // Byte store only touches its lane; byte load is zero-filled
    do_req("st_b_43", 2, 1'b0, 1'b1, 64'h43, SIZE_B, 64'hFFFF_FFFF_FFFF_FFAB, 1'b0, got);
    do_req("ld_d_40b", 2, 1'b1, 1'b0, 64'h40, SIZE_D, 64'h0, 1'b0, got);
    check_eq("tp2_ld_d", got, 64'h1122_3344_AB66_7788);
    do_req("ld_b_43", 2, 1'b1, 1'b0, 64'h43, SIZE_B, 64'h0, 1'b0, got);
    check_eq("tp2_ld_b", got, 64'h0000_0000_0000_00AB);
    do_req("ld_h_44", 2, 1'b1, 1'b0, 64'h44, SIZE_H, 64'h0, 1'b0, got);
    check_eq("ld_h_44_val", got, 64'h0000_0000_0000_3344);

    // Misaligned accesses: error, held read data, no write
    do_req("ld_h_41", 2, 1'b1, 1'b0, 64'h41, SIZE_H, 64'h0, 1'b0, got);
    check_eq("tp3_ld_h_hold", got, 64'h0000_0000_0000_3344);
    do_req("st_w_46", 2, 1'b0, 1'b1, 64'h46, SIZE_W, 64'h9999_9999_9999_9999, 1'b0, got);
    do_req("ld_d_chk1", 2, 1'b1, 1'b0, 64'h40, SIZE_D, 64'h0, 1'b0, got);
    check_eq("tp3_ram_same", got, 64'h1122_3344_AB66_7788);

    // Both enables: error, no write
    do_req("both_en", 2, 1'b1, 1'b1, 64'h40, SIZE_D, 64'h0, 1'b0, got);
    // Enables pulsed during WAIT are ignored
    do_req("ld_w_pulse", 2, 1'b1, 1'b0, 64'h44, SIZE_W, 64'h0, 1'b1, got);
    check_eq("tp4_ld_w", got, 64'h0000_0000_1122_3344);
    repeat (3) begin
      @(negedge clock);
      check_eq("tp4_no_extra_ack", 64'(ack2), 64'd0);
    end
    do_req("ld_d_chk2", 2, 1'b1, 1'b0, 64'h40, SIZE_D, 64'h0, 1'b0, got);
    check_eq("tp4_ram_same", got, 64'h1122_3344_AB66_7788);

    // Reset while a store waits: aborted, never written
    data_address = 64'h40; size = SIZE_D; write_data = 64'hDEAD_BEEF_0BAD_F00D;
    wr2 = 1'b1;
    @(posedge clock);
    @(negedge clock);
    wr2 = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    last_rd[0] = '0;
    last_rd[1] = '0;
    check_eq("tp5_busy",  64'(busy2), 64'd0);
    check_eq("tp5_ack",   64'(ack2), 64'd0);
    check_eq("tp5_error", 64'(err2), 64'd0);
    check_eq("tp5_rdata", rdata2, 64'd0);
    repeat (4) begin
      @(negedge clock);
      check_eq("tp5_no_ack", 64'(ack2), 64'd0);
    end
    do_req("ld_d_after_rst", 2, 1'b1, 1'b0, 64'h40, SIZE_D, 64'h0, 1'b0, got);
    check_eq("tp5_old_data", got, 64'h1122_3344_AB66_7788);

    // Zero wait states: ack one cycle after acceptance, aliasing
    do_req("z_st_d_40", 0, 1'b0, 1'b1, 64'h40, SIZE_D, 64'hCAFE_F00D_1234_5678, 1'b0, got);
    do_req("z_ld_alias", 0, 1'b1, 1'b0, 64'h40 + (64'd1 << (ADDR_SIZE + 3)), SIZE_D, 64'h0, 1'b0, got);
    check_eq("tp6_alias", got, 64'hCAFE_F00D_1234_5678);
    do_req("z_ld_w_44", 0, 1'b1, 1'b0, 64'h44, SIZE_W, 64'h0, 1'b0, got);
    check_eq("tp6_ld_w", got, 64'h0000_0000_CAFE_F00D);

    // Back-to-back requests held high: ack on every other cycle
    data_address = 64'h40; size = SIZE_D; write_data = '0;
    rd0 = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clock);
      if (n % 2 == 1) begin
        model(0, 1'b1, 1'b0, 64'h40, SIZE_D, 64'h0, eerr, erd);
        check_eq("tp6_b2b_ack", 64'(ack0), 64'd1);
        check_eq("tp6_b2b_rdata", rdata0, erd);
      end else begin
        check_eq("tp6_b2b_gap", 64'(ack0), 64'd0);
      end
    end
    rd0 = 1'b0;
    repeat (2) @(negedge clock);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
